// File: rtl/ultrasonic_driver.sv
// ultrasonic_driver: HC-SR04 trigger generator and echo-to-centimetre converter
module ultrasonic_driver #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TRIG_US    = 10,
   parameter int PERIOD_MS  = 60,
   parameter int TIMEOUT_US = 25_000,
   parameter int NEAR_CM    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       echo_signal,
   output logic       trig_signal,
   output logic [8:0] distance_cm,
   output logic       dist_valid,
   output logic       near,
   output logic       timeout
);
   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int PERIOD_US = PERIOD_MS * 1000;
   localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
   localparam int PW = $clog2(PERIOD_US + 1);
   localparam int TMAX = TRIG_US > TIMEOUT_US ? TRIG_US : TIMEOUT_US;
   localparam int TW = $clog2(TMAX + 1);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE_OK, DONE_TO} state_t;

   state_t state, nxt;
   logic [DW-1:0] div_cnt;
   logic [PW-1:0] per_cnt;
   logic [TW-1:0] timer;
   logic [5:0] sub;
   logic [8:0] cm, cm_inc;
   logic us_tick, first, echo_s1, echo_s2, echo_d, echo_rise, echo_fall, tmo;

   assign us_tick = div_cnt == DW'(DIV - 1);
   assign echo_rise = echo_s2 & ~echo_d;
   assign echo_fall = ~echo_s2 & echo_d;
   assign tmo = us_tick && timer == TW'(TIMEOUT_US - 1);
   // cm value including the tick happening this cycle, so the final microsecond is not lost
   assign cm_inc = (us_tick && sub == 6'd57 && cm != 9'h1FF) ? cm + 9'd1 : cm;

   // 2-FF synchronizer on the echo pin plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst)
      if (!rst) {echo_s1, echo_s2, echo_d} <= '0;
      else {echo_s1, echo_s2, echo_d} <= {echo_signal, echo_s1, echo_s2};

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;

   // next-state decode; echo edges take priority over a coincident timeout
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = (us_tick && enable && (first || per_cnt == PW'(PERIOD_US - 1))) ? TRIG : IDLE;
         TRIG:      nxt = (us_tick && timer == TW'(TRIG_US - 1)) ? WAIT_ECHO : TRIG;
         WAIT_ECHO: nxt = echo_rise ? MEASURE : tmo ? DONE_TO : WAIT_ECHO;
         MEASURE:   nxt = echo_fall ? DONE_OK : tmo ? DONE_TO : MEASURE;
         default:   nxt = IDLE;
      endcase
   end

   // microsecond prescaler, saturating period counter and per-state microsecond timer
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div_cnt <= '0;
         per_cnt <= '0;
         timer <= '0;
         first <= 1'b1;
      end else begin
         div_cnt <= us_tick ? '0 : div_cnt + DW'(1);
         per_cnt <= (state == IDLE && nxt == TRIG) ? '0 :
                    (us_tick && per_cnt != PW'(PERIOD_US - 1)) ? per_cnt + PW'(1) : per_cnt;
         timer <= (nxt != state || state == IDLE) ? '0 : us_tick ? timer + TW'(1) : timer;
         first <= first && nxt != TRIG;
      end

   // echo timing: 58 us per centimetre, held at zero until the echo rises
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sub <= '0;
         cm <= '0;
      end else if (state == WAIT_ECHO) begin
         sub <= '0;
         cm <= '0;
      end else if (state == MEASURE && us_tick) begin
         sub <= sub == 6'd57 ? '0 : sub + 6'd1;
         cm <= cm_inc;
      end

   // registered pin and result outputs, loaded as the FSM enters the matching state
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         trig_signal <= 1'b0;
         dist_valid <= 1'b0;
         distance_cm <= '0;
         near <= 1'b0;
         timeout <= 1'b0;
      end else begin
         trig_signal <= nxt == TRIG;
         dist_valid <= nxt == DONE_OK || nxt == DONE_TO;
         if (nxt == DONE_OK) begin
            distance_cm <= cm_inc;
            near <= cm_inc <= 9'(NEAR_CM);
            timeout <= 1'b0;
         end else if (nxt == DONE_TO) begin
            distance_cm <= 9'h1FF;
            near <= 1'b0;
            timeout <= 1'b1;
         end
      end
endmodule

// File: tb/tb_ultrasonic_driver.sv
// tb_ultrasonic_driver: vector table, random echoes and reset/enable corner cases
module tb_ultrasonic_driver;
   localparam int TIMEOUT_US = 1500;
   localparam int NEAR_CM = 20;
   localparam int PERIOD = 2000;

   typedef struct {
      int dly;
      int width;
      int exp_d;
      int exp_n;
      int exp_t;
   } vec_t;

   logic clk = 0, rst = 0, enable = 0, echo_signal = 0;
   logic trig_signal, dist_valid, near, timeout;
   logic [8:0] distance_cm;
   int cyc = 0, n_valid = 0, v_cyc = 0, v_d = 0, v_n = 0, v_t = 0;
   int passed = 0, total = 0, last_trig = 0;
   vec_t tbl[10];

   ultrasonic_driver #(
      .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(2), .TIMEOUT_US(TIMEOUT_US), .NEAR_CM(NEAR_CM)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .echo_signal(echo_signal), .trig_signal(trig_signal),
      .distance_cm(distance_cm), .dist_valid(dist_valid), .near(near), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // capture every strobe with its payload and cycle
   always @(negedge clk)
      if (dist_valid) begin
         n_valid = n_valid + 1;
         v_cyc = cyc;
         v_d = distance_cm;
         v_n = near;
         v_t = timeout;
      end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // reference: an echo of w microseconds is floor(w/58) cm; none or too long is a timeout
   function automatic void model(input int w, output int d, output int n, output int t);
      t = (w == 0 || w >= TIMEOUT_US) ? 1 : 0;
      d = t ? 511 : (w / 58 > 511 ? 511 : w / 58);
      n = (!t && d <= NEAR_CM) ? 1 : 0;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, " trig"}, trig_signal, 0);
      check({tag, " distance"}, distance_cm, 0);
      check({tag, " valid"}, dist_valid, 0);
      check({tag, " near"}, near, 0);
      check({tag, " timeout"}, timeout, 0);
   endtask

   task automatic run(input string tag, input int dly, input int w, input int exp_d, input int exp_n,
                      input int exp_t, input bit chk_period, input bit pre_high, input bit drop_en);
      int t, t0, nv0;
      nv0 = n_valid;
      t = 0;
      if (pre_high) echo_signal = 1;
      while (!trig_signal && t < 3 * PERIOD) begin
         tick();
         t++;
      end
      check({tag, " trig_seen"}, trig_signal, 1);
      if (!trig_signal) return;
      if (chk_period) check({tag, " period"}, cyc - last_trig, PERIOD);
      last_trig = cyc;
      t0 = cyc;
      t = 0;
      while (trig_signal && t < 100) begin
         tick();
         t++;
      end
      check({tag, " trig_width"}, t, 10);
      repeat (dly) tick();
      if (pre_high) begin
         echo_signal = 0;
         repeat (20) tick();
      end
      if (w > 0) begin
         echo_signal = 1;
         for (int i = 0; i < w; i++) begin
            tick();
            if (drop_en && i == w / 2) enable = 0;
         end
         echo_signal = 0;
      end
      t = 0;
      while (n_valid == nv0 && t < 3 * PERIOD) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check({tag, " strobes"}, n_valid - nv0, 1);
      check({tag, " distance"}, v_d, exp_d);
      check({tag, " near"}, v_n, exp_n);
      check({tag, " timeout"}, v_t, exp_t);
      if (w == 0) check({tag, " to_latency"}, v_cyc - t0, 1510);
   endtask

   initial begin
      int w, dly, d, n, to, t, seen, nv0;
      tbl[0] = '{100, 580, 10, 1, 0};
      tbl[1] = '{100, 1450, 25, 0, 0};
      tbl[2] = '{100, 1218, 21, 0, 0};
      tbl[3] = '{100, 1160, 20, 1, 0};
      tbl[4] = '{0, 0, 511, 0, 1};
      tbl[5] = '{100, 580, 10, 1, 0};
      tbl[6] = '{50, 57, 0, 1, 0};
      tbl[7] = '{50, 1161, 20, 1, 0};
      tbl[8] = '{10, 1600, 511, 0, 1};
      tbl[9] = '{200, 1217, 20, 1, 0};

      enable = 1;
      repeat (3) tick();
      check_zero("reset");
      rst = 1;
      tick();
      check("trig_after_reset", trig_signal, 1);
      check("dist_before_strobe", distance_cm, 0);

      for (int i = 0; i < 10; i++)
         run($sformatf("vec%0d", i), tbl[i].dly, tbl[i].width, tbl[i].exp_d, tbl[i].exp_n, tbl[i].exp_t,
             i > 0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1450));
         dly = $urandom_range(5, 300);
         model(w, d, n, to);
         run($sformatf("rnd%0d_w%0d", i, w), dly, w, d, n, to, 1, 0, 0);
      end

      run("stuck_high", 100, 290, 5, 1, 0, 1, 1, 0);

      run("en_drop", 100, 580, 10, 1, 0, 1, 0, 1);
      seen = 0;
      repeat (2500) begin
         tick();
         if (trig_signal) seen++;
      end
      check("no_trig_disabled", seen, 0);
      enable = 1;
      tick();
      check("trig_on_enable", trig_signal, 1);
      run("after_en", 100, 580, 10, 1, 0, 0, 0, 0);

      t = 0;
      while (!trig_signal && t < 3 * PERIOD) begin
         tick();
         t++;
      end
      check("rst_trig_seen", trig_signal, 1);
      repeat (4) tick();
      nv0 = n_valid;
      rst = 0;
      #1;
      check_zero("rst_mid_trig");
      repeat (5) tick();
      check("rst_trig_no_strobe", n_valid - nv0, 0);
      rst = 1;
      tick();
      check("trig_after_rst2", trig_signal, 1);
      run("post_rst", 100, 580, 10, 1, 0, 0, 0, 0);

      t = 0;
      while (!trig_signal && t < 3 * PERIOD) begin
         tick();
         t++;
      end
      t = 0;
      while (trig_signal && t < 100) begin
         tick();
         t++;
      end
      repeat (100) tick();
      echo_signal = 1;
      repeat (300) tick();
      nv0 = n_valid;
      rst = 0;
      #1;
      check_zero("rst_mid_meas");
      echo_signal = 0;
      repeat (20) tick();
      check("rst_meas_no_strobe", n_valid - nv0, 0);
      rst = 1;
      tick();
      check("trig_after_rst3", trig_signal, 1);
      run("final", 100, 1450, 25, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
